barrier_client: RTL

Participant-side endpoint of the barrier protocol. It collects barrier requests from a group of N_WARPS local warps and serializes them into one-per-cycle `arrive`/`id` strobes toward the central barrier collector. It holds each arrived warp stalled until the collector's broadcast generation advances, then emits a one-cycle per-warp release. One instance sits in each SM scheduler slice, between the warp scheduler and the shared barrier collector.

---
 rtl/barrier_client_if.sv | 40 ++++
 rtl/barrier_client.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/barrier_client_if.sv
// Barrier participant bus: groups the scheduler-facing request/status lines
// and the collector-facing arrive/id/generation lines of one barrier_client.
//   bar_req      : per-warp BAR request pulse (from warp scheduler)
//   gen_in       : generation broadcast (from collector)
//   arrive, id   : arrival strobe and collector id (to collector)
//   waiting      : per-warp stall indication (to warp scheduler)
//   warp_release : per-warp one-cycle resume pulse (to warp scheduler)
// Modport master is the barrier_client side; slave is its environment.
interface barrier_client_if #(
  parameter int unsigned N_WARPS   = 8,
  parameter int unsigned ID_WIDTH  = 5,
  parameter int unsigned GEN_WIDTH = 8
);

  logic [N_WARPS-1:0]   bar_req;
  logic [GEN_WIDTH-1:0] gen_in;
  logic                 arrive;
  logic [ID_WIDTH-1:0]  id;
  logic [N_WARPS-1:0]   waiting;
  logic [N_WARPS-1:0]   warp_release;

  modport master (
    input  bar_req,
    input  gen_in,
    output arrive,
    output id,
    output waiting,
    output warp_release
  );

  modport slave (
    output bar_req,
    output gen_in,
    input  arrive,
    input  id,
    input  waiting,
    input  warp_release
  );

endinterface

// File: rtl/barrier_client.sv
// Participant-side barrier endpoint. Collects BAR requests from N_WARPS local
// warps, serializes them round-robin into one-per-cycle arrive/id strobes for
// the central collector, stalls each arrived warp until the collector's
// generation broadcast moves away from the value seen at arrival, then pulses
// a one-cycle per-warp release.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bif        : barrier_client_if.master (bar_req, gen_in in;
//                arrive, id, waiting, warp_release out)
module barrier_client #(
  parameter int unsigned N_WARPS   = 8,
  parameter int unsigned ID_WIDTH  = 5,
  parameter int unsigned ID_BASE   = 0,
  parameter int unsigned GEN_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  barrier_client_if.master bif
);

  localparam int unsigned IDX_W = (N_WARPS > 1) ? $clog2(N_WARPS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_ARRV = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  logic [N_WARPS-1:0][1:0]           state_q, state_d;
  logic [N_WARPS-1:0][GEN_WIDTH-1:0] gen_cap_q, gen_cap_d;
  logic [IDX_W-1:0]                  ptr_q, ptr_d;
  logic                              arrive_q, arrive_d;
  logic [ID_WIDTH-1:0]               id_q, id_d;
  logic [N_WARPS-1:0]                rel_q, rel_d;

  logic [N_WARPS-1:0]                pend_c;
  logic [N_WARPS-1:0]                waiting_c;
  logic                              grant_vld_c;
  logic [IDX_W-1:0]                  grant_idx_c;
  logic [IDX_W-1:0]                  cand_c;

  // Per-warp status decode
  always_comb begin
    pend_c    = '0;
    waiting_c = '0;
    for (int w = 0; w < N_WARPS; w++) begin
      pend_c[w]    = (state_q[w] == ST_PEND);
      waiting_c[w] = (state_q[w] != ST_IDLE);
    end
  end

  // Round-robin arbiter: first PEND warp at or after ptr_q, wrapping.
  // ptr_q holds the index one past the last grant; N_WARPS is a power of
  // two so the wrap is plain truncation.
  always_comb begin
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    cand_c      = '0;
    for (int i = 0; i < N_WARPS; i++) begin
      cand_c = ptr_q + IDX_W'(i);
      if (!grant_vld_c && pend_c[cand_c]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = cand_c;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    gen_cap_d = gen_cap_q;
    ptr_d     = ptr_q;
    arrive_d  = 1'b0;
    id_d      = '0;
    rel_d     = '0;

    for (int w = 0; w < N_WARPS; w++) begin
      case (state_q[w])
        ST_IDLE: begin
          if (bif.bar_req[w]) begin
            state_d[w] = ST_PEND;
          end
        end
        ST_PEND: begin
          if (grant_vld_c && (grant_idx_c == IDX_W'(w))) begin
            state_d[w] = ST_ARRV;
          end
        end
        ST_ARRV: begin
          // Capture the generation seen during the arrival cycle; a collector
          // update on this same edge is therefore detected next cycle.
          state_d[w]   = ST_WAIT;
          gen_cap_d[w] = bif.gen_in;
        end
        ST_WAIT: begin
          // Inequality rather than ordering so counter wrap still releases
          if (bif.gen_in != gen_cap_q[w]) begin
            state_d[w] = ST_IDLE;
            rel_d[w]   = 1'b1;
          end
        end
        default: begin
          state_d[w] = ST_IDLE;
        end
      endcase
    end

    // The granted warp is the only one in ARRV next cycle, so the strobe
    // is registered alongside its state transition.
    if (grant_vld_c) begin
      arrive_d = 1'b1;
      id_d     = ID_WIDTH'(ID_BASE) + ID_WIDTH'(grant_idx_c);
      ptr_d    = grant_idx_c + IDX_W'(1);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= '0;
      gen_cap_q <= '0;
      ptr_q     <= '0;
      arrive_q  <= 1'b0;
      id_q      <= '0;
      rel_q     <= '0;
    end else begin
      state_q   <= state_d;
      gen_cap_q <= gen_cap_d;
      ptr_q     <= ptr_d;
      arrive_q  <= arrive_d;
      id_q      <= id_d;
      rel_q     <= rel_d;
    end
  end

  assign bif.arrive       = arrive_q;
  assign bif.id           = id_q;
  assign bif.warp_release = rel_q;
  assign bif.waiting      = waiting_c;

endmodule
